// File: rtl/spi_oversampled_responder_if.sv
// SPI pin and register-file bundle for the oversampled responder.
// The responder drives the outputs, the initiator side drives sclk/serial_in.
interface spi_oversampled_responder_if #(
  parameter int N_REGS = 16
);
  logic                sclk;
  logic                serial_in;
  logic                serial_out;
  logic [8*N_REGS-1:0] regs;
  logic                wr_strobe;
  logic [6:0]          wr_addr;
  logic [7:0]          wr_data;
  logic                busy;
  logic                frame_err;

  modport slave (
    input  sclk,
    input  serial_in,
    output serial_out,
    output regs,
    output wr_strobe,
    output wr_addr,
    output wr_data,
    output busy,
    output frame_err
  );

  modport master (
    output sclk,
    output serial_in,
    input  serial_out,
    input  regs,
    input  wr_strobe,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  frame_err
  );
endinterface

// File: rtl/spi_oversampled_responder.sv
// SPI register responder: sclk is oversampled by clk, frames are
// {rw,addr} then data (write) or count + N bytes out (read).
module spi_oversampled_responder #(
  parameter int N_REGS      = 16,
  parameter int IDLE_CYCLES = 64
) (
  input logic clk,
  input logic rstn,
  spi_oversampled_responder_if.slave bus
);

  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [7:0]    NR   = 8'(N_REGS);
  localparam logic [6:0]    LAST = 7'(N_REGS - 1);
  localparam logic [IW-1:0] IMAX = IW'(IDLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_RCOUNT = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          sclk_s1_q, sclk_s2_q, sclk_d3_q;
  logic          din_s1_q, din_s2_q;
  logic [7:0]    shift_q, out_q, wdata_q, left_q;
  logic [6:0]    addr_q, raddr_q;
  logic [2:0]    bit_q;
  logic [IW-1:0] idle_q;
  logic          commit_q, load_q, sout_q;
  logic          wr_strobe_q, frame_err_q;
  logic [6:0]    wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    regs_q [N_REGS];

  logic       rise, fall, tmo, last;
  logic [7:0] byte_in, rd_byte;
  logic [6:0] raddr_nx;

  assign rise = sclk_s2_q & ~sclk_d3_q;
  assign fall = ~sclk_s2_q & sclk_d3_q;
  assign last = (bit_q == 3'd7);
  assign tmo  = (state_q != S_IDLE) && !(rise || fall)
             && (idle_q == IMAX);
  assign byte_in  = {shift_q[6:0], din_s2_q};
  assign raddr_nx = (raddr_q == LAST) ? 7'd0 : raddr_q + 7'd1;
  assign rd_byte  = ({1'b0, raddr_q} < NR)
                  ? regs_q[raddr_q[AW-1:0]] : 8'h00;

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = S_IDLE;
    end else if (rise) begin
      case (state_q)
        S_IDLE:   state_d = S_CMD;
        S_CMD:    if (last) state_d = byte_in[7] ? S_WDATA : S_RCOUNT;
        S_WDATA:  if (last) state_d = S_DRAIN;
        S_RCOUNT: if (last) state_d = (byte_in == 8'h00) ? S_DRAIN : S_RDATA;
        S_RDATA:  if (last && left_q == 8'd1) state_d = S_DRAIN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_d3_q   <= 1'b0;
      din_s1_q    <= 1'b0;
      din_s2_q    <= 1'b0;
      shift_q     <= 8'h00;
      out_q       <= 8'h00;
      wdata_q     <= 8'h00;
      left_q      <= 8'h00;
      addr_q      <= 7'd0;
      raddr_q     <= 7'd0;
      bit_q       <= 3'd0;
      idle_q      <= '0;
      commit_q    <= 1'b0;
      load_q      <= 1'b0;
      sout_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= 8'h00;
    end else begin
      sclk_s1_q   <= bus.sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_d3_q   <= sclk_s2_q;
      din_s1_q    <= bus.serial_in;
      din_s2_q    <= din_s1_q;
      state_q     <= state_d;
      frame_err_q <= tmo && (state_q != S_DRAIN);
      wr_strobe_q <= 1'b0;
      commit_q    <= 1'b0;

      if (state_q == S_IDLE || rise || fall) idle_q <= '0;
      else if (idle_q != IMAX)               idle_q <= idle_q + 1'b1;

      // commit runs independently of the FSM so a DRAIN timeout cannot drop it
      if (commit_q && ({1'b0, addr_q} < NR)) begin
        regs_q[addr_q[AW-1:0]] <= wdata_q;
        wr_strobe_q <= 1'b1;
        wr_addr_q   <= addr_q;
        wr_data_q   <= wdata_q;
      end

      if (tmo) begin
        bit_q   <= 3'd0;
        shift_q <= 8'h00;
        load_q  <= 1'b0;
        sout_q  <= 1'b0;
      end else if (rise) begin
        case (state_q)
          S_IDLE: begin
            shift_q <= {7'd0, din_s2_q};
            bit_q   <= 3'd1;
          end
          S_CMD, S_WDATA, S_RCOUNT: begin
            shift_q <= byte_in;
            bit_q   <= bit_q + 3'd1;
            if (last && state_q == S_CMD) addr_q <= byte_in[6:0];
            if (last && state_q == S_WDATA) begin
              wdata_q  <= byte_in;
              commit_q <= 1'b1;
            end
            if (last && state_q == S_RCOUNT) begin
              left_q  <= byte_in;
              raddr_q <= addr_q;
              load_q  <= 1'b1;
            end
          end
          S_RDATA: begin
            bit_q <= bit_q + 3'd1;
            if (last) begin
              raddr_q <= raddr_nx;
              left_q  <= left_q - 8'd1;
              load_q  <= 1'b1;
              if (left_q == 8'd1) sout_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (fall && state_q == S_RDATA) begin
        if (load_q) begin
          sout_q <= rd_byte[7];
          out_q  <= {rd_byte[6:0], 1'b0};
          load_q <= 1'b0;
        end else begin
          sout_q <= out_q[7];
          out_q  <= {out_q[6:0], 1'b0};
        end
      end
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_regs
    assign bus.regs[8*k +: 8] = regs_q[k];
  end

  assign bus.serial_out = sout_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_oversampled_responder.sv
// Randomized scoreboard bench for the SPI register responder.
// Initiator tasks push expectations; a monitor process checks DUT outputs.
module tb_spi_oversampled_responder;

  localparam int N_REGS = 16;
  localparam int IDLE   = 64;
  localparam int HALF   = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_oversampled_responder_if #(.N_REGS(N_REGS)) bus();

  spi_oversampled_responder #(
    .N_REGS(N_REGS),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [N_REGS];
  logic [14:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  got_q [$];
  int          exp_err_q [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: pops expectations whenever the DUT presents an output
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.wr_strobe) begin
          check("wr_strobe_expected", 32'(exp_wr_q.size() != 0), 1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check("wr_addr", bus.wr_addr, e[14:8]);
            check("wr_data", bus.wr_data, e[7:0]);
          end
        end
        if (bus.frame_err) begin
          check("frame_err_expected", 32'(exp_err_q.size() != 0), 1);
          if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
        end
        while (got_q.size() != 0) begin
          logic [7:0] g;
          g = got_q.pop_front();
          check("rd_expected", 32'(exp_rd_q.size() != 0), 1);
          if (exp_rd_q.size() != 0) check("rd_byte", g, exp_rd_q.pop_front());
        end
      end
    end
  end

  task automatic xfer_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.serial_in = tx[i];
      tick(HALF);
      rx = {rx[6:0], bus.serial_out};
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx);
    logic [7:0] rx;
    xfer_bits(tx, 8, rx);
  endtask

  task automatic recv_byte();
    logic [7:0] rx;
    xfer_bits(8'h00, 8, rx);
    got_q.push_back(rx);
  endtask

  task automatic check_regs();
    for (int k = 0; k < N_REGS; k++)
      check($sformatf("regs%0d", k), bus.regs[8*k +: 8], model[k]);
  endtask

  task automatic frame_end();
    tick(IDLE + 12);
    check("busy_idle", bus.busy, 0);
    check("sout_idle", bus.serial_out, 0);
    check_regs();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    send_byte({1'b1, a});
    if (int'(a) < N_REGS) begin
      model[a] = d;
      exp_wr_q.push_back({a, d});
    end
    send_byte(d);
    frame_end();
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    int cur;
    cur = int'(a);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(cur < N_REGS ? model[cur] : 8'h00);
      cur = (cur == N_REGS - 1) ? 0 : (cur + 1) % 128;
    end
    send_byte({1'b0, a});
    send_byte(8'(n));
    for (int i = 0; i < n; i++) recv_byte();
    frame_end();
  endtask

  initial begin
    logic [7:0] rx;
    for (int k = 0; k < N_REGS; k++) model[k] = 8'h00;
    bus.sclk = 1'b0;
    bus.serial_in = 1'b0;
    rstn = 1'b0;
    tick(3);
    check("rst_busy", bus.busy, 0);
    check("rst_sout", bus.serial_out, 0);
    check("rst_strobe", bus.wr_strobe, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check_regs();
    rstn = 1'b1;
    tick(3);

    do_write(7'd1, 8'hF0);
    do_write(7'd2, 8'h03);
    do_read(7'd2, 2);
    do_write(7'd15, 8'hA5);
    do_write(7'd0, 8'h3C);
    do_read(7'd15, 2);
    do_write(7'd16, 8'h55);
    do_read(7'd16, 1);
    do_read(7'd126, 4);
    do_read(7'd5, 0);

    // aborted write: command plus half a data byte, then silence
    exp_err_q.push_back(1);
    send_byte(8'h81);
    xfer_bits(8'hA0, 4, rx);
    frame_end();
    do_write(7'd1, 8'h66);

    // reset in the middle of a data byte
    send_byte(8'h83);
    xfer_bits(8'h77, 4, rx);
    rstn = 1'b0;
    for (int k = 0; k < N_REGS; k++) model[k] = 8'h00;
    tick(2);
    check("midrst_busy", bus.busy, 0);
    check("midrst_sout", bus.serial_out, 0);
    check("midrst_reg3", bus.regs[8*3 +: 8], 8'h00);
    rstn = 1'b1;
    tick(3);
    do_write(7'd3, 8'h77);
    do_read(7'd3, 1);

    for (int it = 0; it < 20; it++) begin
      logic [6:0] a;
      a = 7'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
      else do_read(a, int'($urandom_range(0, 3)));
    end

    tick(20);
    check("wr_left", exp_wr_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("err_left", exp_err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
